// File: rtl/record_arbiter_pkg.sv
// Shared types for the record arbiter: the record carried to the function unit
// and the arbiter FSM state encoding.
package record_arbiter_pkg;

    typedef struct packed {
        logic signed [31:0] x;
        logic        [31:0] y;
    } record_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        WAIT,
        RETURN
    } arb_state_t;

endpackage

// File: rtl/record_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Reusable by any scheduler that shares one unit among N requesters.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDXW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/record_arbiter.sv
// Round-robin arbiter sharing one record->result function unit among N
// requesters, with a single transaction in flight and registered handshakes.
module record_arbiter
    import record_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  record_t         req_in [N],
    input  logic [N-1:0]    req_in_sync,
    output logic [N-1:0]    req_in_notify,
    output record_t         fu_out,
    input  logic            fu_out_sync,
    output logic            fu_out_notify,
    input  logic [31:0]     fu_in,
    input  logic            fu_in_sync,
    output logic            fu_in_notify,
    output logic [31:0]     rsp_out [N],
    input  logic [N-1:0]    rsp_out_sync,
    output logic [N-1:0]    rsp_out_notify,
    output logic [IDXW-1:0] grant_id,
    output logic            busy
);

    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    arb_state_t      state_reg, state_next;
    logic [IDXW-1:0] grant_reg, grant_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]    req_notify_reg, req_notify_next;
    record_t         fu_rec_reg, fu_rec_next;
    logic            fu_out_notify_reg, fu_out_notify_next;
    logic            fu_in_notify_reg, fu_in_notify_next;
    logic [N-1:0]    rsp_notify_reg, rsp_notify_next;
    logic [31:0]     rsp_data_reg [N];
    logic            rsp_we;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req   (req_in_sync),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            grant_reg         <= '0;
            ptr_reg           <= '0;
            req_notify_reg    <= '0;
            fu_rec_reg        <= '0;
            fu_out_notify_reg <= 1'b0;
            fu_in_notify_reg  <= 1'b0;
            rsp_notify_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            grant_reg         <= grant_next;
            ptr_reg           <= ptr_next;
            req_notify_reg    <= req_notify_next;
            fu_rec_reg        <= fu_rec_next;
            fu_out_notify_reg <= fu_out_notify_next;
            fu_in_notify_reg  <= fu_in_notify_next;
            rsp_notify_reg    <= rsp_notify_next;
        end
    end

    // Each state waits only on its own partner's sync; everything else holds.
    always_comb begin
        state_next         = state_reg;
        grant_next         = grant_reg;
        ptr_next           = ptr_reg;
        req_notify_next    = req_notify_reg;
        fu_rec_next        = fu_rec_reg;
        fu_out_notify_next = fu_out_notify_reg;
        fu_in_notify_next  = fu_in_notify_reg;
        rsp_notify_next    = rsp_notify_reg;
        rsp_we             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next      = pick_idx;
                    req_notify_next = ONE_HOT0 << pick_idx;
                    state_next      = GRANT;
                end
            end
            GRANT: begin
                if (req_in_sync[grant_reg]) begin
                    fu_rec_next        = req_in[grant_reg];
                    req_notify_next    = '0;
                    fu_out_notify_next = 1'b1;
                    state_next         = SEND;
                end
            end
            SEND: begin
                if (fu_out_sync) begin
                    fu_out_notify_next = 1'b0;
                    fu_in_notify_next  = 1'b1;
                    state_next         = WAIT;
                end
            end
            WAIT: begin
                if (fu_in_sync) begin
                    rsp_we            = 1'b1;
                    fu_in_notify_next = 1'b0;
                    rsp_notify_next   = ONE_HOT0 << grant_reg;
                    state_next        = RETURN;
                end
            end
            RETURN: begin
                if (rsp_out_sync[grant_reg]) begin
                    rsp_notify_next = '0;
                    ptr_next        = (grant_reg == IDXW'(N - 1)) ? '0 : grant_reg + 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_rsp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_data_reg[gi] <= '0;
            end else if (rsp_we && grant_reg == IDXW'(gi)) begin
                rsp_data_reg[gi] <= fu_in;
            end
        end
        assign rsp_out[gi] = rsp_data_reg[gi];
    end

    assign req_in_notify  = req_notify_reg;
    assign fu_out         = fu_rec_reg;
    assign fu_out_notify  = fu_out_notify_reg;
    assign fu_in_notify   = fu_in_notify_reg;
    assign rsp_out_notify = rsp_notify_reg;
    assign grant_id       = grant_reg;
    assign busy           = (state_reg != IDLE);

endmodule
